// File: rtl/pixel_readout_if.sv
// Output pixel stream: registered beat with valid/ready handshake and end-of-frame marker.
interface pixel_readout_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/pixel_readout_controller.sv
// Frame sequencer for the pixel array: erase -> expose -> ramp-ADC convert -> row-major readout
// onto a valid/ready pixel stream. Every output comes straight from a flop.
module pixel_readout_controller #(
    parameter int PIXEL_ARRAY_HEIGHT = 128,
    parameter int PIXEL_ARRAY_WIDTH  = 128,
    parameter int PIXEL_BITS         = 8,
    parameter int OUTPUT_BUS_WIDTH   = 8,
    parameter int ERASE_CYCLES       = 5,
    parameter int EXPOSE_CYCLES      = 255
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       erase,
    output logic                                       expose,
    output logic                                       convert,
    output logic [PIXEL_BITS-1:0]                      adc_count,
    output logic                                       read_en,
    output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0]      row_sel,
    output logic [$clog2(PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH)-1:0] col_grp,
    input  logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]     pix_data_in,
    output logic                                       frame_done,
    pixel_readout_if.master                            out_bus
);

    localparam int GROUPS  = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int ROW_W   = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int COL_W   = $clog2(GROUPS);
    localparam int DATA_W  = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam int CNT_MAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]      ERASE_LAST  = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      EXPOSE_LAST = CNT_W'(EXPOSE_CYCLES - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST    = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [COL_W-1:0]      COL_LAST    = COL_W'(GROUPS - 1);
    localparam logic [PIXEL_BITS-1:0] ADC_MAX     = {PIXEL_BITS{1'b1}};

    if (PIXEL_ARRAY_WIDTH % OUTPUT_BUS_WIDTH != 0) begin : g_bad_width
        $error("PIXEL_ARRAY_WIDTH must be a multiple of OUTPUT_BUS_WIDTH");
    end
    if (ERASE_CYCLES < 1 || EXPOSE_CYCLES < 1) begin : g_bad_cycles
        $error("ERASE_CYCLES and EXPOSE_CYCLES must be at least 1");
    end
    if (PIXEL_ARRAY_HEIGHT < 2 || GROUPS < 2) begin : g_bad_geometry
        $error("array needs at least 2 rows and 2 column groups");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PIXEL_BITS-1:0] adc_q, adc_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                left_q, left_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                erase_q, erase_d;
    logic                expose_q, expose_d;
    logic                convert_q, convert_d;
    logic                read_en_q, read_en_d;
    logic                at_end;

    assign at_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adc_d    = adc_q;
        row_d    = row_q;
        col_d    = col_q;
        left_d   = left_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ERASE;
                    cnt_d   = '0;
                end
            end
            S_ERASE: begin
                if (cnt_q == ERASE_LAST) begin
                    state_d = S_EXPOSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXPOSE: begin
                if (cnt_q == EXPOSE_LAST) begin
                    state_d = S_CONVERT;
                    cnt_d   = '0;
                    adc_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CONVERT: begin
                if (adc_q == ADC_MAX) begin
                    state_d = S_READ;
                    adc_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    left_d  = 1'b1;
                end else begin
                    adc_d = adc_q + PIXEL_BITS'(1);
                end
            end
            S_READ: begin
                // A new beat may replace the current one in the same cycle it is accepted.
                if (left_q && (!valid_q || out_bus.out_ready)) begin
                    data_d  = pix_data_in;
                    valid_d = 1'b1;
                    last_d  = at_end;
                    if (at_end) begin
                        row_d  = '0;
                        col_d  = '0;
                        left_d = 1'b0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else if (valid_q && out_bus.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (!left_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered copies of the next state so they line up with it.
        busy_d    = (state_d != S_IDLE);
        erase_d   = (state_d == S_ERASE);
        expose_d  = (state_d == S_EXPOSE);
        convert_d = (state_d == S_CONVERT);
        read_en_d = (state_d == S_READ) && left_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            adc_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            left_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            read_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adc_q     <= adc_d;
            row_q     <= row_d;
            col_q     <= col_d;
            left_q    <= left_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            erase_q   <= erase_d;
            expose_q  <= expose_d;
            convert_q <= convert_d;
            read_en_q <= read_en_d;
        end
    end

    assign busy              = busy_q;
    assign erase             = erase_q;
    assign expose            = expose_q;
    assign convert           = convert_q;
    assign adc_count         = adc_q;
    assign read_en           = read_en_q;
    assign row_sel           = row_q;
    assign col_grp           = col_q;
    assign frame_done        = done_q;
    assign out_bus.out_data  = data_q;
    assign out_bus.out_valid = valid_q;
    assign out_bus.out_last  = last_q;

endmodule

// File: tb/tb_pixel_readout_controller.sv
// Directed bench: small array (4x16, 8-pixel bus, 4-bit ramp) plus one default-size instance.
module tb_pixel_readout_controller;

    localparam int S_R = 4, S_W = 16, S_BUS = 8, S_BITS = 4, S_ER = 2, S_EX = 3;
    localparam int S_G = S_W / S_BUS;
    localparam int S_BEATS = S_R * S_G;
    localparam int S_RAMP = 1 << S_BITS;

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // ---------------- small instance ----------------
    logic        start_s;
    logic        busy_s, erase_s, expose_s, convert_s, read_en_s, done_s;
    logic [3:0]  adc_s;
    logic [1:0]  row_s;
    logic [0:0]  col_s;
    logic [31:0] pix_in_s;

    pixel_readout_if #(.DATA_W(32)) bus_s ();

    function automatic logic [31:0] pix_s(input int r, input int c);
        logic [31:0] k;
        k = 32'(r * S_G + c + 1);
        return (k * 32'h2545_F491) ^ 32'h5A5A_C3C3;
    endfunction

    assign pix_in_s = pix_s(int'(row_s), int'(col_s));

    pixel_readout_controller #(
        .PIXEL_ARRAY_HEIGHT(S_R), .PIXEL_ARRAY_WIDTH(S_W), .PIXEL_BITS(S_BITS),
        .OUTPUT_BUS_WIDTH(S_BUS), .ERASE_CYCLES(S_ER), .EXPOSE_CYCLES(S_EX)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start_s), .busy(busy_s),
        .erase(erase_s), .expose(expose_s), .convert(convert_s), .adc_count(adc_s),
        .read_en(read_en_s), .row_sel(row_s), .col_grp(col_s), .pix_data_in(pix_in_s),
        .frame_done(done_s), .out_bus(bus_s)
    );

    // ---------------- default-size instance ----------------
    logic        start_b;
    logic        busy_b, erase_b, expose_b, convert_b, read_en_b, done_b;
    logic [7:0]  adc_b;
    logic [6:0]  row_b;
    logic [3:0]  col_b;
    logic [63:0] pix_in_b;

    pixel_readout_if #(.DATA_W(64)) bus_b ();

    function automatic logic [63:0] pix_b(input int r, input int c);
        logic [63:0] k;
        k = 64'(r * 16 + c + 1);
        return (k * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    assign pix_in_b = pix_b(int'(row_b), int'(col_b));

    pixel_readout_controller dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b),
        .erase(erase_b), .expose(expose_b), .convert(convert_b), .adc_count(adc_b),
        .read_en(read_en_b), .row_sel(row_b), .col_grp(col_b), .pix_data_in(pix_in_b),
        .frame_done(done_b), .out_bus(bus_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_s(input string tag);
        chk({tag, "_busy"}, busy_s, 0);
        chk({tag, "_erase"}, erase_s, 0);
        chk({tag, "_expose"}, expose_s, 0);
        chk({tag, "_convert"}, convert_s, 0);
        chk({tag, "_adc"}, adc_s, 0);
        chk({tag, "_rden"}, read_en_s, 0);
        chk({tag, "_row"}, row_s, 0);
        chk({tag, "_col"}, col_s, 0);
        chk({tag, "_data"}, bus_s.out_data, 0);
        chk({tag, "_valid"}, bus_s.out_valid, 0);
        chk({tag, "_last"}, bus_s.out_last, 0);
        chk({tag, "_done"}, done_s, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge showing frame_done.
    task automatic run_frame(input string tag, input bit rand_ready, input bit hold_start);
        int b = 0, issued = 0, cyc = 0;
        bit exp_valid;
        start_s = 1'b1;
        @(negedge clk);
        start_s = hold_start;
        for (int i = 0; i < S_ER; i++) begin
            chk({tag, "_erase"}, erase_s, 1);
            chk({tag, "_erbusy"}, busy_s, 1);
            @(negedge clk);
        end
        for (int i = 0; i < S_EX; i++) begin
            chk({tag, "_exp_er"}, erase_s, 0);
            chk({tag, "_expose"}, expose_s, 1);
            @(negedge clk);
        end
        for (int i = 0; i < S_RAMP; i++) begin
            chk({tag, "_cv_ex"}, expose_s, 0);
            chk({tag, "_convert"}, convert_s, 1);
            chk({tag, "_adc"}, adc_s, 64'(i));
            @(negedge clk);
        end
        chk({tag, "_cv_end"}, convert_s, 0);
        chk({tag, "_adc_end"}, adc_s, 0);
        while (b < S_BEATS && cyc < 200) begin
            exp_valid = (issued > b);
            chk({tag, "_busy"}, busy_s, 1);
            chk({tag, "_rden"}, read_en_s, 64'(issued < S_BEATS));
            chk({tag, "_row"}, row_s, issued < S_BEATS ? 64'(issued / S_G) : 0);
            chk({tag, "_col"}, col_s, issued < S_BEATS ? 64'(issued % S_G) : 0);
            chk({tag, "_valid"}, bus_s.out_valid, 64'(exp_valid));
            if (exp_valid) begin
                chk({tag, "_data"}, bus_s.out_data, pix_s(b / S_G, b % S_G));
                chk({tag, "_last"}, bus_s.out_last, 64'(b == S_BEATS - 1));
            end
            bus_s.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (issued < S_BEATS && (!exp_valid || bus_s.out_ready)) issued++;
            if (exp_valid && bus_s.out_ready) b++;
            cyc++;
            @(negedge clk);
        end
        bus_s.out_ready = 1'b1;
        chk({tag, "_timeout"}, 64'(cyc < 200), 1);
        if (!rand_ready) chk({tag, "_read_cycles"}, 64'(cyc), 64'(S_BEATS + 1));
        chk({tag, "_done"}, done_s, 1);
        chk({tag, "_done_busy"}, busy_s, 0);
        chk({tag, "_done_valid"}, bus_s.out_valid, 0);
        chk({tag, "_done_last"}, bus_s.out_last, 0);
        chk({tag, "_done_rden"}, read_en_s, 0);
        chk({tag, "_done_row"}, row_s, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, conv, abad, dbad, b, nlast, lastidx;
        reset_n = 1'b0;
        start_s = 1'b1;
        start_b = 1'b0;
        bus_s.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;

        // 1: reset held with start asserted, then release into IDLE
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle_s("rst");
        end
        reset_n = 1'b1;
        start_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_idle_s("idle");
        end

        // 2: full frame, always ready
        run_frame("f_rdy", 1'b0, 1'b0);
        @(negedge clk);
        chk("f_rdy_done_pulse", done_s, 0);
        chk("f_rdy_idle", busy_s, 0);

        // 3: random backpressure
        run_frame("f_bp", 1'b1, 1'b0);
        @(negedge clk);
        chk("f_bp_done_pulse", done_s, 0);

        // 4: start held through a frame, then back-to-back frame from the frame_done cycle
        run_frame("f_hold", 1'b0, 1'b1);
        run_frame("f_b2b", 1'b0, 1'b0);
        @(negedge clk);
        chk("f_b2b_idle", busy_s, 0);

        // 5: reset during the third beat aborts the frame
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (S_ER + S_EX + S_RAMP) @(negedge clk);
        chk("abort_rden", read_en_s, 1);
        repeat (3) @(negedge clk);
        chk("abort_valid", bus_s.out_valid, 1);
        chk("abort_beat2", bus_s.out_data, pix_s(1, 0));
        reset_n = 1'b0;
        @(negedge clk);
        chk_idle_s("abort");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", done_s, 0);
            chk("abort_idle", busy_s, 0);
        end
        run_frame("f_after", 1'b0, 1'b0);
        @(negedge clk);

        // 6: default-size array, always ready
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!convert_b && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("big_conv_start", 64'(n), 64'(5 + 255));
        conv = 0;
        abad = 0;
        while (convert_b && conv < 1000) begin
            if (adc_b !== conv[7:0]) abad++;
            conv++;
            @(negedge clk);
        end
        chk("big_conv_len", 64'(conv), 256);
        chk("big_adc_ramp", 64'(abad), 0);
        n = 0;
        b = 0;
        nlast = 0;
        lastidx = -1;
        dbad = 0;
        while (!done_b && n < 5000) begin
            if (bus_b.out_valid) begin
                if (bus_b.out_data !== pix_b(b / 16, b % 16)) dbad++;
                if (bus_b.out_last) begin
                    nlast++;
                    lastidx = b;
                end
                b++;
            end
            n++;
            @(negedge clk);
        end
        chk("big_done", done_b, 1);
        chk("big_beats", 64'(b), 2048);
        chk("big_data", 64'(dbad), 0);
        chk("big_nlast", 64'(nlast), 1);
        chk("big_last_idx", 64'(lastidx), 2047);
        chk("big_read_cycles", 64'(n), 2049);
        chk("big_busy", busy_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
